mmio_spart: RTL and testbench

//  Memory-mapped serial port. Sits directly downstream of the CPU data-memory bus (addr/re/we/wdata/rdata).

---
 rtl/mmio_spart.sv | 340 ++++++++++++++++++++++++++++++++++
 tb/tb_mmio_spart.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/mmio_spart.sv
// mmio_spart: memory-mapped 8N1 serial port on the CPU data-memory bus.
//   A 4-word register window holds DATA (TX push / RX pop), STATUS,
//   DIV_LO and DIV_HI. TX and RX bytes are buffered in small FIFOs.
// Ports:
//   clk, rst          system clock, asynchronous active-high reset
//   addr/re/we/wdata  CPU data bus request (single cycle)
//   rdata             read data, combinational from addr/re
//   txd               serial transmit line, idle high
//   rxd               serial receive line, asynchronous to clk
//   rx_rdy            high while the RX FIFO holds at least one byte
module mmio_spart #(
  parameter logic [15:0] BASE_ADDR  = 16'hC004,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter logic [15:0] DIV_RESET  = 16'd5208
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] addr,
  input  logic        re,
  input  logic        we,
  input  logic [15:0] wdata,
  output logic [15:0] rdata,
  output logic        txd,
  input  logic        rxd,
  output logic        rx_rdy
);

  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = 4;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [15:0] DIV_MIN = 16'd16;

  typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} ser_state_t;

  // Bus decode; a read strobe masks a simultaneous write
  logic       sel;
  logic [1:0] off;
  logic       rd_acc;
  logic       wr_acc;
  logic       wdata_unused;

  assign sel          = (addr[15:2] == BASE_ADDR[15:2]);
  assign off          = addr[1:0];
  assign rd_acc       = sel & re;
  assign wr_acc       = sel & we & ~re;
  assign wdata_unused = ^wdata[15:8];

  // Divisor register with a floor of 16 clocks per bit
  logic [15:0] div_q;
  logic [15:0] div_wr;

  always_comb begin
    div_wr = div_q;
    if (off == 2'd2) div_wr[7:0]  = wdata[7:0];
    else             div_wr[15:8] = wdata[7:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 div_q <= DIV_RESET;
    else if (wr_acc && off[1]) div_q <= (div_wr < DIV_MIN) ? DIV_MIN : div_wr;
  end

  // TX FIFO
  logic [7:0]    tx_mem [FIFO_DEPTH];
  logic [PW-1:0] tx_wp, tx_rp;
  logic [CW-1:0] tx_cnt, tx_cnt_n, tx_free;
  logic          tx_push, tx_pop, tx_full, tx_empty;
  logic [7:0]    tx_head;

  assign tx_full  = (tx_cnt == DEPTH_C);
  assign tx_empty = (tx_cnt == '0);
  assign tx_free  = DEPTH_C - tx_cnt;
  assign tx_head  = tx_mem[tx_rp];
  assign tx_push  = wr_acc && (off == 2'd0) && !tx_full;

  always_comb begin
    tx_cnt_n = tx_cnt;
    if (tx_push && !tx_pop)      tx_cnt_n = tx_cnt + CW'(1);
    else if (!tx_push && tx_pop) tx_cnt_n = tx_cnt - CW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_wp  <= '0;
      tx_rp  <= '0;
      tx_cnt <= '0;
    end else begin
      if (tx_push) tx_wp <= tx_wp + PW'(1);
      if (tx_pop)  tx_rp <= tx_rp + PW'(1);
      tx_cnt <= tx_cnt_n;
    end
  end

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wp] <= wdata[7:0];
  end

  // RX FIFO; a pop frees the slot for a same-cycle push even when full
  logic [7:0]    rx_mem [FIFO_DEPTH];
  logic [PW-1:0] rx_wp, rx_rp;
  logic [CW-1:0] rx_cnt, rx_cnt_n;
  logic          rx_push, rx_wr, rx_pop, rx_full, rx_empty;
  logic [7:0]    rx_head;
  logic [7:0]    rx_sh;

  assign rx_full  = (rx_cnt == DEPTH_C);
  assign rx_empty = (rx_cnt == '0);
  assign rx_head  = rx_mem[rx_rp];
  assign rx_pop   = rd_acc && (off == 2'd0) && !rx_empty;
  assign rx_wr    = rx_push && (!rx_full || rx_pop);

  always_comb begin
    rx_cnt_n = rx_cnt;
    if (rx_wr && !rx_pop)      rx_cnt_n = rx_cnt + CW'(1);
    else if (!rx_wr && rx_pop) rx_cnt_n = rx_cnt - CW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_wp  <= '0;
      rx_rp  <= '0;
      rx_cnt <= '0;
      rx_rdy <= 1'b0;
    end else begin
      if (rx_wr)  rx_wp <= rx_wp + PW'(1);
      if (rx_pop) rx_rp <= rx_rp + PW'(1);
      rx_cnt <= rx_cnt_n;
      rx_rdy <= (rx_cnt_n != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rx_wr) rx_mem[rx_wp] <= rx_sh;
  end

  // Sticky error flags: cleared by a STATUS read, a new event wins
  logic ferr, ovf;
  logic ferr_set, ovf_set;
  logic status_rd;

  assign status_rd = rd_acc && (off == 2'd1);
  assign ovf_set   = rx_push && rx_full && !rx_pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ferr <= 1'b0;
      ovf  <= 1'b0;
    end else begin
      ferr <= (ferr & ~status_rd) | ferr_set;
      ovf  <= (ovf & ~status_rd) | ovf_set;
    end
  end

  // Read mux
  always_comb begin
    rdata = 16'h0000;
    if (rd_acc) begin
      case (off)
        2'd0:    rdata = rx_empty ? 16'h0000 : {8'h00, rx_head};
        2'd1:    rdata = {ferr, ovf, 6'b000000, tx_free, rx_cnt};
        2'd2:    rdata = {8'h00, div_q[7:0]};
        default: rdata = {8'h00, div_q[15:8]};
      endcase
    end
  end

  // TX FSM: each state holds for tx_div clocks, divisor latched per frame
  ser_state_t tx_state, tx_state_n;
  logic [15:0] tx_tmr, tx_tmr_n, tx_div, tx_div_n;
  logic [2:0]  tx_bit, tx_bit_n;
  logic [7:0]  tx_sh, tx_sh_n;
  logic        txd_n;
  logic        tx_begin;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state <= ST_IDLE;
      tx_tmr   <= '0;
      tx_div   <= DIV_RESET;
      tx_bit   <= '0;
      tx_sh    <= '0;
      txd      <= 1'b1;
    end else begin
      tx_state <= tx_state_n;
      tx_tmr   <= tx_tmr_n;
      tx_div   <= tx_div_n;
      tx_bit   <= tx_bit_n;
      tx_sh    <= tx_sh_n;
      txd      <= txd_n;
    end
  end

  always_comb begin
    tx_state_n = tx_state;
    tx_tmr_n   = (tx_tmr == '0) ? tx_tmr : tx_tmr - 16'd1;
    tx_div_n   = tx_div;
    tx_bit_n   = tx_bit;
    tx_sh_n    = tx_sh;
    txd_n      = txd;
    tx_pop     = 1'b0;
    tx_begin   = 1'b0;
    case (tx_state)
      ST_IDLE: begin
        txd_n = 1'b1;
        if (!tx_empty) tx_begin = 1'b1;
      end
      ST_START: begin
        if (tx_tmr == '0) begin
          tx_state_n = ST_DATA;
          tx_tmr_n   = tx_div - 16'd1;
          tx_bit_n   = 3'd0;
          txd_n      = tx_sh[0];
        end
      end
      ST_DATA: begin
        if (tx_tmr == '0) begin
          tx_tmr_n = tx_div - 16'd1;
          if (tx_bit == 3'd7) begin
            tx_state_n = ST_STOP;
            txd_n      = 1'b1;
          end else begin
            tx_bit_n = tx_bit + 3'd1;
            tx_sh_n  = {1'b0, tx_sh[7:1]};
            txd_n    = tx_sh[1];
          end
        end
      end
      ST_STOP: begin
        if (tx_tmr == '0) begin
          // Chain straight into the next frame when more data is queued
          if (!tx_empty) begin
            tx_begin = 1'b1;
          end else begin
            tx_state_n = ST_IDLE;
            txd_n      = 1'b1;
          end
        end
      end
      default: begin
        tx_state_n = ST_IDLE;
        txd_n      = 1'b1;
      end
    endcase
    if (tx_begin) begin
      tx_pop     = 1'b1;
      tx_state_n = ST_START;
      tx_sh_n    = tx_head;
      tx_div_n   = div_q;
      tx_tmr_n   = div_q - 16'd1;
      txd_n      = 1'b0;
    end
  end

  // RX synchroniser plus one extra stage for falling-edge detection
  logic rxd_s1, rxd_s2, rxd_s3;
  logic rx_fall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rxd_s1 <= 1'b1;
      rxd_s2 <= 1'b1;
      rxd_s3 <= 1'b1;
    end else begin
      rxd_s1 <= rxd;
      rxd_s2 <= rxd_s1;
      rxd_s3 <= rxd_s2;
    end
  end

  assign rx_fall = rxd_s3 & ~rxd_s2;

  // RX FSM: half-bit wait to the start-bit centre, then full-bit strides
  ser_state_t rx_state, rx_state_n;
  logic [15:0] rx_tmr, rx_tmr_n, rx_div, rx_div_n;
  logic [2:0]  rx_bit, rx_bit_n;
  logic [7:0]  rx_sh_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_state <= ST_IDLE;
      rx_tmr   <= '0;
      rx_div   <= DIV_RESET;
      rx_bit   <= '0;
      rx_sh    <= '0;
    end else begin
      rx_state <= rx_state_n;
      rx_tmr   <= rx_tmr_n;
      rx_div   <= rx_div_n;
      rx_bit   <= rx_bit_n;
      rx_sh    <= rx_sh_n;
    end
  end

  always_comb begin
    rx_state_n = rx_state;
    rx_tmr_n   = (rx_tmr == '0) ? rx_tmr : rx_tmr - 16'd1;
    rx_div_n   = rx_div;
    rx_bit_n   = rx_bit;
    rx_sh_n    = rx_sh;
    rx_push    = 1'b0;
    ferr_set   = 1'b0;
    case (rx_state)
      ST_IDLE: begin
        if (rx_fall) begin
          rx_state_n = ST_START;
          rx_div_n   = div_q;
          rx_tmr_n   = {1'b0, div_q[15:1]} - 16'd1;
        end
      end
      ST_START: begin
        if (rx_tmr == '0) begin
          if (rxd_s2) begin
            rx_state_n = ST_IDLE;
          end else begin
            rx_state_n = ST_DATA;
            rx_tmr_n   = rx_div - 16'd1;
            rx_bit_n   = 3'd0;
          end
        end
      end
      ST_DATA: begin
        if (rx_tmr == '0) begin
          rx_sh_n  = {rxd_s2, rx_sh[7:1]};
          rx_tmr_n = rx_div - 16'd1;
          if (rx_bit == 3'd7) rx_state_n = ST_STOP;
          else                rx_bit_n   = rx_bit + 3'd1;
        end
      end
      ST_STOP: begin
        if (rx_tmr == '0) begin
          rx_state_n = ST_IDLE;
          if (rxd_s2) rx_push  = 1'b1;
          else        ferr_set = 1'b1;
        end
      end
      default: rx_state_n = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mmio_spart.sv
// tb_mmio_spart: directed bench for mmio_spart covering register access,
//   divisor clamping, TX framing and back-to-back frames, RX receive,
//   framing error, false start, overflow and full-FIFO pop/push overlap.
module tb_mmio_spart;

  localparam logic [15:0] A_DATA = 16'hC004;
  localparam logic [15:0] A_STAT = 16'hC005;
  localparam logic [15:0] A_DLO  = 16'hC006;
  localparam logic [15:0] A_DHI  = 16'hC007;

  logic        clk = 1'b0;
  logic        rst, re, we, rxd;
  logic [15:0] addr, wdata;
  logic [15:0] rdata;
  logic        txd, rx_rdy;
  logic [15:0] d, d0;

  int checks = 0;
  int errors = 0;

  mmio_spart dut (
    .clk   (clk),
    .rst   (rst),
    .addr  (addr),
    .re    (re),
    .we    (we),
    .wdata (wdata),
    .rdata (rdata),
    .txd   (txd),
    .rxd   (rxd),
    .rx_rdy(rx_rdy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Bus tasks are entered on a falling edge; the access lands on the next rising edge
  task automatic cpu_write(input logic [15:0] a, input logic [15:0] v);
    addr = a; wdata = v; we = 1'b1;
    @(negedge clk);
    we = 1'b0; addr = 16'h0000;
  endtask

  task automatic cpu_read(input logic [15:0] a, output logic [15:0] v);
    addr = a; re = 1'b1;
    #1 v = rdata;
    @(negedge clk);
    re = 1'b0; addr = 16'h0000;
  endtask

  // Drive one 8N1 frame at 16 clocks per bit
  task automatic send_rx(input logic [7:0] b, input logic stop);
    rxd = 1'b0;
    repeat (16) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (16) @(negedge clk);
    end
    rxd = stop;
    repeat (16) @(negedge clk);
    rxd = 1'b1;
  endtask

  // Cycle k (1..160) of a TX frame is the k-th falling edge after the start edge
  task automatic expect_tx_frame(input logic [7:0] b, input int first, input string tag);
    int   bad;
    logic e;
    bad = 0;
    for (int k = first; k <= 160; k++) begin
      if (k <= 16)       e = 1'b0;
      else if (k <= 144) e = b[3'((k - 17) / 16)];
      else               e = 1'b1;
      @(negedge clk);
      if (txd !== e) bad++;
    end
    check(tag, 16'(bad), 16'd0);
  endtask

  task automatic expect_tx_idle(input int n, input string tag);
    int bad;
    bad = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (txd !== 1'b1) bad++;
    end
    check(tag, 16'(bad), 16'd0);
  endtask

  initial begin
    rst = 1'b1; re = 1'b0; we = 1'b0; addr = 16'h0000; wdata = 16'h0000; rxd = 1'b1;
    repeat (3) @(negedge clk);
    check("txd_in_reset", 16'(txd), 16'd1);
    check("rx_rdy_in_reset", 16'(rx_rdy), 16'd0);
    rst = 1'b0;
    @(negedge clk);

    // Reset register state
    cpu_read(A_STAT, d); check("status_reset", d, 16'h0080);
    cpu_read(A_DLO, d);  check("div_lo_reset", d, 16'h0058);
    cpu_read(A_DHI, d);  check("div_hi_reset", d, 16'h0014);
    cpu_read(A_DATA, d); check("data_empty", d, 16'h0000);

    // rdata is zero without a selected read
    addr = A_STAT; #1 check("rdata_no_re", rdata, 16'h0000);
    addr = 16'hC008; re = 1'b1; #1 check("rdata_unselected", rdata, 16'h0000);
    re = 1'b0; addr = 16'h0000;
    @(negedge clk);

    // Divisor access and clamp
    cpu_write(A_DHI, 16'h0000);
    cpu_write(A_DLO, 16'h0005);
    cpu_read(A_DLO, d); check("div_clamp_lo", d, 16'h0010);
    cpu_write(A_DHI, 16'hFF12);
    cpu_read(A_DHI, d); check("div_hi_byte", d, 16'h0012);
    cpu_write(A_DHI, 16'h0000);
    cpu_read(A_DHI, d); check("div_hi_zero", d, 16'h0000);
    cpu_read(A_DLO, d); check("div_lo_16", d, 16'h0010);

    // re and we together: the write is ignored
    addr = A_DATA; wdata = 16'h0077; re = 1'b1; we = 1'b1;
    @(negedge clk);
    re = 1'b0; we = 1'b0; addr = 16'h0000;
    repeat (3) @(negedge clk);
    check("rewe_txd_idle", 16'(txd), 16'd1);
    cpu_read(A_STAT, d); check("rewe_status", d, 16'h0080);

    // Single TX frame 0xA5, then line stays high
    cpu_write(A_DATA, 16'h00A5);
    check("tx_before_start", 16'(txd), 16'd1);
    expect_tx_frame(8'hA5, 1, "tx_frame_a5");
    expect_tx_idle(16, "tx_idle_after_a5");

    // Busy transmitter: 9-byte burst, last one dropped, frames back-to-back
    cpu_write(A_DATA, 16'h0011);
    for (int i = 0; i < 9; i++) cpu_write(A_DATA, 16'h0020 + 16'(i));
    cpu_read(A_STAT, d); check("tx_full_status", d, 16'h0000);
    expect_tx_frame(8'h11, 11, "tx_burst_first");
    for (int i = 0; i < 8; i++) expect_tx_frame(8'h20 + 8'(i), 1, $sformatf("tx_burst_%0d", i));
    expect_tx_idle(40, "tx_idle_after_burst");
    cpu_read(A_STAT, d); check("tx_drained_status", d, 16'h0080);

    // RX good frame
    send_rx(8'h3C, 1'b1);
    repeat (4) @(negedge clk);
    check("rx_rdy_set", 16'(rx_rdy), 16'd1);
    cpu_read(A_DATA, d); check("rx_data_3c", d, 16'h003C);
    check("rx_rdy_clear", 16'(rx_rdy), 16'd0);

    // RX framing error: byte dropped, ferr sticky until STATUS read
    send_rx(8'h55, 1'b0);
    repeat (4) @(negedge clk);
    check("ferr_no_push", 16'(rx_rdy), 16'd0);
    cpu_read(A_STAT, d); check("ferr_status", d, 16'h8080);
    cpu_read(A_STAT, d); check("ferr_cleared", d, 16'h0080);

    // False start: short low pulse is rejected
    rxd = 1'b0;
    repeat (4) @(negedge clk);
    rxd = 1'b1;
    repeat (200) @(negedge clk);
    check("false_start_rdy", 16'(rx_rdy), 16'd0);
    cpu_read(A_STAT, d); check("false_start_status", d, 16'h0080);

    // Overflow: 9 frames without pops
    for (int i = 1; i <= 9; i++) send_rx(8'(i), 1'b1);
    repeat (4) @(negedge clk);
    cpu_read(A_STAT, d); check("ovf_status", d, 16'h4088);
    cpu_read(A_STAT, d); check("ovf_cleared", d, 16'h0088);

    // Pop on the same edge as a push into a full FIFO (stop sample at edge M+155)
    fork
      send_rx(8'h0A, 1'b1);
      begin
        repeat (154) @(negedge clk);
        cpu_read(A_DATA, d0);
      end
    join
    check("overlap_pop_data", d0, 16'h0001);
    repeat (4) @(negedge clk);
    cpu_read(A_STAT, d); check("overlap_no_ovf", d, 16'h0088);
    for (int i = 0; i < 8; i++) begin
      cpu_read(A_DATA, d);
      check($sformatf("rx_drain_%0d", i), d, (i < 7) ? 16'(i + 2) : 16'h000A);
    end
    check("rx_rdy_drained", 16'(rx_rdy), 16'd0);

    // Reset in mid-frame returns txd high at once and restores defaults
    cpu_write(A_DATA, 16'h0000);
    repeat (3) @(negedge clk);
    check("tx_midframe_low", 16'(txd), 16'd0);
    rst = 1'b1;
    #1 check("tx_async_reset", 16'(txd), 16'd1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    cpu_read(A_STAT, d); check("status_after_reset", d, 16'h0080);
    cpu_read(A_DLO, d);  check("div_after_reset", d, 16'h0058);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
